// File: rtl/riscv_pkg.sv
// Shared core package for the 3-stage RISC-V core.
// Holds the conditional-branch opcode and the 2-bit saturating counter
// encodings used by the branch predictor.
package riscv_pkg;

  localparam logic [6:0] BR_OPC = 7'h63;

  // 2-bit direction counter: MSB is the predicted direction.
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,  // strong not-taken
    CTR_WNT = 2'b01,  // weak not-taken
    CTR_WT  = 2'b10,  // weak taken
    CTR_ST  = 2'b11   // strong taken
  } ctr_e;

  localparam ctr_e CTR_RESET = CTR_WNT;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// sat_counter2: next-state function of a 2-bit saturating up/down counter,
// plus the value loaded when a table entry is (re)allocated.
// Ports:
//   ctr_i     current counter value
//   taken_i   resolved branch direction (1 = count up, 0 = count down)
//   next_o    saturating +1 / -1 of ctr_i
//   alloc_o   load value for a fresh entry (weak in the resolved direction)
module sat_counter2
  import riscv_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] next_o,
  output logic [1:0] alloc_o
);

  always_comb begin
    next_o  = ctr_i;
    alloc_o = taken_i ? CTR_WT : CTR_WNT;
    if (taken_i) begin
      if (ctr_i != CTR_ST) next_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != CTR_SNT) next_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped, tagged table of 2-bit saturating counters.
// Predicts the conditional branch in FD and trains on the branch resolved in X.
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset
//   pc_guess         PC of the FD instruction
//   is_br_guess      FD instruction is a conditional branch
//   pc_check         PC of the X instruction
//   is_br_check      X instruction is a conditional branch
//   br_taken_check   resolved direction of the X branch
//   pred_taken       combinational prediction for the FD branch
//   br_count         resolved branch count (wraps)
//   mispred_count    misprediction count (wraps)
module branch_predictor
  import riscv_pkg::*;
#(
  parameter int PC_WIDTH = 32,
  parameter int LINES    = 8,
  parameter int INDEX_W  = $clog2(LINES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PC_WIDTH-1:0] pc_guess,
  input  logic                is_br_guess,
  input  logic [PC_WIDTH-1:0] pc_check,
  input  logic                is_br_check,
  input  logic                br_taken_check,
  output logic                pred_taken,
  output logic [31:0]         br_count,
  output logic [31:0]         mispred_count
);

  localparam int TAG_W = PC_WIDTH - INDEX_W - 2;

  logic [LINES-1:0]            valid_q, valid_d;
  logic [LINES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [LINES-1:0][1:0]       ctr_q, ctr_d;
  logic                        pred_x_q, pred_x_d;
  logic [31:0]                 br_count_q, br_count_d;
  logic [31:0]                 mispred_count_q, mispred_count_d;

  logic [INDEX_W-1:0] guess_idx, check_idx;
  logic [TAG_W-1:0]   guess_tag, check_tag;
  logic               check_hit;
  logic [1:0]         ctr_next, ctr_alloc;

  // Byte-offset bits never select an entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_guess[1:0], pc_check[1:0]};

  assign guess_idx = pc_guess[INDEX_W+1:2];
  assign guess_tag = pc_guess[PC_WIDTH-1:INDEX_W+2];
  assign check_idx = pc_check[INDEX_W+1:2];
  assign check_tag = pc_check[PC_WIDTH-1:INDEX_W+2];

  // Lookup reads the registered table only, so a same-cycle update to the
  // same index is not visible until the following cycle.
  assign pred_taken = is_br_guess && valid_q[guess_idx] &&
                      (tag_q[guess_idx] == guess_tag) && ctr_q[guess_idx][1];

  assign check_hit = valid_q[check_idx] && (tag_q[check_idx] == check_tag);

  sat_counter2 u_sat (
    .ctr_i   (ctr_q[check_idx]),
    .taken_i (br_taken_check),
    .next_o  (ctr_next),
    .alloc_o (ctr_alloc)
  );

  always_comb begin
    valid_d         = valid_q;
    tag_d           = tag_q;
    ctr_d           = ctr_q;
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    // pred_x follows FD unconditionally: FD always advances into X.
    pred_x_d        = pred_taken;
    if (is_br_check) begin
      br_count_d = br_count_q + 32'd1;
      if (pred_x_q != br_taken_check) mispred_count_d = mispred_count_q + 32'd1;
      if (check_hit) begin
        ctr_d[check_idx] = ctr_next;
      end else begin
        valid_d[check_idx] = 1'b1;
        tag_d[check_idx]   = check_tag;
        ctr_d[check_idx]   = ctr_alloc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q         <= '0;
      tag_q           <= '0;
      for (int i = 0; i < LINES; i++) ctr_q[i] <= CTR_RESET;
      pred_x_q        <= 1'b0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      valid_q         <= valid_d;
      tag_q           <= tag_d;
      ctr_q           <= ctr_d;
      pred_x_q        <= pred_x_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the 3-stage RISC-V core. It supplies `pred_taken` for the conditional branch in FD and trains on the resolved outcome (`br_taken`) of the branch in X. Storage is a direct-mapped, tagged table of 2-bit saturating counters. Two 32-bit performance counters record the number of resolved branches and the number of mispredictions.

## Interface
Parameters:
- `PC_WIDTH`, 32, width of PC inputs
- `LINES`, 8, number of table entries; power of two, ≥2
- `INDEX_W`, `$clog2(LINES)`, derived; not overridden

Ports:
- `clk`  in  1  core clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `pc_guess`  in  PC_WIDTH  PC of the instruction in FD
- `is_br_guess`  in  1  FD instruction is a conditional branch (opcode 0x63)
- `pc_check`  in  PC_WIDTH  PC of the instruction in X
- `is_br_check`  in  1  X instruction is a conditional branch
- `br_taken_check`  in  1  resolved direction of the X branch
- `pred_taken`  out  1  prediction for the FD branch
- `br_count`  out  32  number of resolved branches
- `mispred_count`  out  32  number of mispredicted branches

## Operation
- PC fields:
  - index = `pc[INDEX_W+1:2]`
  - tag = `pc[PC_WIDTH-1:INDEX_W+2]`
  - `pc[1:0]` is ignored
- Each entry holds `valid`, `tag`, and `ctr[1:0]`:
  - 00 = strong not-taken, 01 = weak not-taken, 10 = weak taken, 11 = strong taken
- Lookup (combinational):
  - hit = `valid[idx] && tag[idx]==tag(pc_guess)`
  - `pred_taken = is_br_guess && hit && ctr[idx][1]`
  - a miss, or a non-branch in FD, predicts not-taken (0)
- Prediction pipeline: `pred_x` register captures `pred_taken` every cycle, so it is the prediction made for the instruction now in X. The core does not stall FD→X, so no enable is needed.
- Update, on a clock edge with `is_br_check=1`:
  - hit: `ctr` saturating +1 if taken, −1 if not taken; 11+taken stays 11, 00+not-taken stays 00
  - miss: allocate the entry (overwrite)
    - `valid=1`
    - `tag=tag(pc_check)`
    - `ctr` = 10 if taken, else 01
  - `br_count` += 1
  - `mispred_count` += 1 if `pred_x != br_taken_check`
- No table change when `is_br_check=0`.
- Stats counters wrap modulo 2^32; there is no saturation.

## Timing
- `pred_taken`: zero latency, combinational from `pc_guess`/`is_br_guess` and table state.
- Training: the table reflects an X-stage outcome from the next cycle onward.
- Lookup and update in the same cycle to the same index: lookup returns the pre-update state; there is no bypass.
- Reset (`rst_n`=0, asynchronous, any cycle including mid-update):
  - all `valid`=0, `ctr`=01, tags=0
  - `pred_x`=0
  - `br_count`=0, `mispred_count`=0
  - consequently `pred_taken`=0
- First edge after `rst_n` deasserts performs normal operation.
- Aliasing: two PCs with the same index and different tags evict each other; a lookup by the evicted PC misses and predicts not-taken.

## Structure
- Shared core package `riscv_pkg` holds:
  - `BR_OPC = 7'h63`
  - counter encodings `CTR_SNT/CTR_WNT/CTR_WT/CTR_ST`
  - the reset value `CTR_RESET = CTR_WNT`
- One sub-module, `sat_counter2`: a 2-bit saturating up/down next-state function plus an allocation load value. `branch_predictor` instantiates one shared instance on the update path.
- Table storage is flops, not SRAM: it needs asynchronous read and reset clear.

## Test plan
- Reset then lookup: `rst_n` pulse low; `pc_guess=0x100`, `is_br_guess=1` → `pred_taken=0`, `br_count=0`, `mispred_count=0`.
- Allocate and train:
  - resolve `pc_check=0x100` taken → next cycle lookup 0x100 gives `pred_taken=1` (ctr=10)
  - a second taken outcome → ctr=11
  - one not-taken → ctr=10, still predicts 1
- Saturation: 5 not-taken outcomes at 0x200 → ctr=00. One taken → ctr=01, `pred_taken=0`.
- Alias eviction (LINES=8):
  - train 0x100 taken, then resolve 0x120 not-taken (same index 0, different tag)
  - lookup 0x100 → miss, `pred_taken=0`
- Stats: loop branch at 0x40 resolved taken ×4 then not-taken ×1 from reset, with FD lookups feeding `pred_x` each cycle → `br_count=5`, `mispred_count=2` (first taken, final not-taken).
- Same-cycle hazard and async reset:
  - lookup and update of 0x100 (ctr=01, taken) in the same cycle → `pred_taken=0` that cycle, 1 the next
  - assert `rst_n` low mid-cycle → all outputs 0 immediately, without waiting for `clk`
